// File: rtl/seg7_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_pkg
//   Shared constants for the seven-segment scan driver.
//   Glyph codes are high-true, bit order {g,f,e,d,c,b,a}.
//   SEG7_OFF / SEG7_ALL are the all-dark and all-lit segment codes.
// -----------------------------------------------------------------------------
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG7_OFF     = 7'h00;
  localparam logic [6:0] SEG7_ALL     = 7'h7F;

  localparam logic [6:0] SEG7_GLYPH_0 = 7'h3F;
  localparam logic [6:0] SEG7_GLYPH_1 = 7'h06;
  localparam logic [6:0] SEG7_GLYPH_2 = 7'h5B;
  localparam logic [6:0] SEG7_GLYPH_3 = 7'h4F;
  localparam logic [6:0] SEG7_GLYPH_4 = 7'h66;
  localparam logic [6:0] SEG7_GLYPH_5 = 7'h6D;
  localparam logic [6:0] SEG7_GLYPH_6 = 7'h7D;
  localparam logic [6:0] SEG7_GLYPH_7 = 7'h07;
  localparam logic [6:0] SEG7_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SEG7_GLYPH_9 = 7'h6F;
  localparam logic [6:0] SEG7_GLYPH_A = 7'h77;
  localparam logic [6:0] SEG7_GLYPH_B = 7'h7C;  // lower-case b
  localparam logic [6:0] SEG7_GLYPH_C = 7'h39;
  localparam logic [6:0] SEG7_GLYPH_D = 7'h5E;  // lower-case d
  localparam logic [6:0] SEG7_GLYPH_E = 7'h79;
  localparam logic [6:0] SEG7_GLYPH_F = 7'h71;

  // Apply output polarity to a segment code.
  function automatic logic [6:0] seg7_polarity(input logic [6:0] v, input bit low);
    return low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
//   Combinational hex nibble to seven-segment glyph (high-true).
//   Ports:
//     i_nib    in  4  hex nibble 0..F
//     o_glyph  out 7  {g,f,e,d,c,b,a}, 1 = segment lit
// -----------------------------------------------------------------------------
module seg7_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = SEG7_OFF;
    case (i_nib)
      4'h0: o_glyph = SEG7_GLYPH_0;
      4'h1: o_glyph = SEG7_GLYPH_1;
      4'h2: o_glyph = SEG7_GLYPH_2;
      4'h3: o_glyph = SEG7_GLYPH_3;
      4'h4: o_glyph = SEG7_GLYPH_4;
      4'h5: o_glyph = SEG7_GLYPH_5;
      4'h6: o_glyph = SEG7_GLYPH_6;
      4'h7: o_glyph = SEG7_GLYPH_7;
      4'h8: o_glyph = SEG7_GLYPH_8;
      4'h9: o_glyph = SEG7_GLYPH_9;
      4'hA: o_glyph = SEG7_GLYPH_A;
      4'hB: o_glyph = SEG7_GLYPH_B;
      4'hC: o_glyph = SEG7_GLYPH_C;
      4'hD: o_glyph = SEG7_GLYPH_D;
      4'hE: o_glyph = SEG7_GLYPH_E;
      4'hF: o_glyph = SEG7_GLYPH_F;
      default: o_glyph = SEG7_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Multiplexed seven-segment driver. An internal divide-by-SCAN_DIV prescaler
//   produces the scan tick that steps the digit index 0..DIGITS-1. A new value
//   offered over valid/ready is parked in a pending buffer and committed to the
//   display registers only at the frame boundary, so the display never tears.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN -- when defined, leading zero
//   digits (k>0, digit and all above it zero, own dp off) are kept dark; the
//   blanking mask is computed at commit time.
//
//   Ports:
//     in_clk      in   1          system clock, rising edge
//     reset       in   1          asynchronous, active-high reset
//     in_valid    in   1          upstream offers in_data/dp_in
//     in_ready    out  1          pending buffer empty
//     in_data     in   4*DIGITS   hex nibbles, nibble k -> digit k (0 = rightmost)
//     dp_in       in   DIGITS     decimal point per digit, 1 = lit
//     blank       in   1          1 = all anodes inactive, scan keeps running
//     seg_out     out  7          {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
//     dp_out      out  1          decimal point of current digit
//     an_out      out  DIGITS     one-hot anode enable, polarity per ACTIVE_LOW
//     frame_done  out  1          one-cycle pulse after idx wraps to 0
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  in_clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam bit LOW = (ACTIVE_LOW != 0);

  logic [PS_W-1:0]     r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic                r_pending;
  logic [4*DIGITS-1:0] r_pend_data;
  logic [DIGITS-1:0]   r_pend_dp;
  logic [4*DIGITS-1:0] r_disp;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;
  logic                r_dp_o;
  logic                r_frame_done;

  logic                w_tick;
  logic                w_wrap;
  logic                w_accept;
  logic                w_commit;
  logic [3:0]          w_nib;
  logic [6:0]          w_glyph;
  logic                w_lit;
  logic [DIGITS-1:0]   w_an_hi;

  assign w_tick   = (r_presc == PS_LAST);
  assign w_wrap   = w_tick && (r_idx == IDX_LAST);
  assign w_accept = in_valid && !r_pending;
  // Accept and commit are mutually exclusive: accept needs !pending, commit needs pending.
  assign w_commit = w_wrap && r_pending;
  assign in_ready = ~r_pending;

  // ---- Stage p0: prescaler, digit index, handshake, display registers ----
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_disp    <= '0;
      r_dp      <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      if (w_accept)
        r_pending <= 1'b1;
      else if (w_commit)
        r_pending <= 1'b0;
      if (w_commit) begin
        r_disp <= r_pend_data;
        r_dp   <= r_pend_dp;
      end
    end
  end

  // Pending payload is qualified by r_pending, so it needs no reset.
  always_ff @(posedge in_clk) begin
    if (w_accept) begin
      r_pend_data <= in_data;
      r_pend_dp   <= dp_in;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_mask;
  logic [DIGITS-1:0] w_mask_next;
  logic              w_run;

  // Walk down from the top digit; the run of zeros ends at the first non-zero
  // nibble. Digit 0 is never blanked.
  always_comb begin
    w_mask_next = '1;
    w_run       = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_run = w_run && (r_pend_data[4*k +: 4] == 4'h0);
      if (w_run && !r_pend_dp[k])
        w_mask_next[k] = 1'b0;
    end
  end

  // All digits lit until the first commit.
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset)
      r_mask <= '1;
    else if (w_commit)
      r_mask <= w_mask_next;
  end

  assign w_lit = ~blank & r_mask[r_idx];
`else
  assign w_lit = ~blank;
`endif

  assign w_nib   = r_disp[{r_idx, 2'b00} +: 4];
  assign w_an_hi = w_lit ? (DIGITS'(1) << r_idx) : '0;

  seg7_hex_decode u_decode (
    .i_nib   (w_nib),
    .o_glyph (w_glyph)
  );

  // ---- Stage p1: registered outputs, one cycle behind idx ----
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      r_an         <= LOW ? '1 : '0;
      r_seg        <= seg7_polarity(SEG7_OFF, LOW);
      r_dp_o       <= LOW;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= LOW ? ~w_an_hi : w_an_hi;
      r_seg        <= seg7_polarity(w_glyph, LOW);
      r_dp_o       <= LOW ? ~r_dp[r_idx] : r_dp[r_idx];
      r_frame_done <= w_wrap;
    end
  end

  assign an_out     = r_an;
  assign seg_out    = r_seg;
  assign dp_out     = r_dp_o;
  assign frame_done = r_frame_done;

endmodule
